// File: rtl/pipeline_5_ma.sv
// pipeline_5_ma: memory-access stage. Owns the AHB data phase started by EX,
// aligns load data, turns a two-cycle ERROR response into a misconduct code
// and writes the MAWB registers consumed by WB and EX forwarding.
package p_hardisc;
    localparam int ICTRL_W   = 7;
    localparam int IMISCON_W = 3;
    localparam int F_W       = 4;
    localparam int RF_W      = 5;
    localparam logic [IMISCON_W-1:0] IMISCON_FREE = 3'd0;
    localparam logic [IMISCON_W-1:0] IMISCON_DBER = 3'd6;
endpackage

// state | meaning
// IDLE  | no data phase outstanding
// DATA  | data phase of an accepted transfer in progress
// ERR   | first ERROR cycle seen, waiting for the closing ERROR cycle
module pipeline_5_ma (
    input  logic                            s_clk_i,
    input  logic                            s_resetn_i,
    input  logic                            s_flush_i,
    input  logic                            s_lsu_approve_i,
    input  logic [31:0]                     s_lsu_wdata_i,
    input  logic [p_hardisc::ICTRL_W-1:0]   s_exma_ictrl_i,
    input  logic [p_hardisc::IMISCON_W-1:0] s_exma_imiscon_i,
    input  logic [p_hardisc::F_W-1:0]       s_exma_f_i,
    input  logic [p_hardisc::RF_W-1:0]      s_exma_rd_i,
    input  logic [31:0]                     s_exma_val_i,
    input  logic                            s_d_hready_i,
    input  logic                            s_d_hresp_i,
    input  logic [31:0]                     s_d_hrdata_i,
    output logic [31:0]                     s_d_hwdata_o,
    output logic                            s_stall_o,
    output logic [p_hardisc::ICTRL_W-1:0]   s_mawb_ictrl_o,
    output logic [p_hardisc::IMISCON_W-1:0] s_mawb_imiscon_o,
    output logic [p_hardisc::RF_W-1:0]      s_mawb_rd_o,
    output logic [31:0]                     s_mawb_val_o,
    output logic                            s_mawb_we_o
);
    import p_hardisc::*;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] wdata_q;
    logic        kill_q;
    logic        addr_acc;
    logic        in_xfer;
    logic        is_store;
    logic        is_load;
    logic        err_done;
    logic [1:0]  offset;
    logic [31:0] shifted;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic        sign_bit;
    logic [31:0] aligned;
    logic        we_d;

    // A new address phase is only taken when the bus is ready and we are not
    // closing an ERROR response (EX is expected to be flushed after an error).
    assign addr_acc = s_lsu_approve_i & s_d_hready_i & (state_q != ST_ERR);
    assign in_xfer  = (state_q != ST_IDLE);
    assign s_stall_o = in_xfer & ~s_d_hready_i;
    assign err_done  = s_d_hready_i & ((state_q == ST_ERR) | ((state_q == ST_DATA) & s_d_hresp_i));
    assign is_store  = in_xfer & s_exma_f_i[3];
    assign is_load   = in_xfer & ~s_exma_f_i[3];

    // Data-phase state register
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Data-phase next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (addr_acc) state_d = ST_DATA;
            ST_DATA: begin
                if (s_d_hready_i)     state_d = addr_acc ? ST_DATA : ST_IDLE;
                else if (s_d_hresp_i) state_d = ST_ERR;
            end
            ST_ERR:  if (s_d_hready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store operand captured with the address phase, held through the data phase
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i)   wdata_q <= 32'h0;
        else if (addr_acc) wdata_q <= s_lsu_wdata_i;
    end

    // Lane replication uses the size of the instruction now sitting in MA
    always_comb begin
        s_d_hwdata_o = {4{wdata_q[7:0]}};
        if (s_exma_f_i[1])      s_d_hwdata_o = wdata_q;
        else if (s_exma_f_i[0]) s_d_hwdata_o = {2{wdata_q[15:0]}};
    end

    // Remembers a flush that arrived while stalled so the late completion is dropped
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i)    kill_q <= 1'b0;
        else if (s_stall_o) kill_q <= kill_q | s_flush_i;
        else                kill_q <= 1'b0;
    end

    // Load alignment and sign/zero extension
    always_comb begin
        offset   = s_exma_val_i[1:0];
        shifted  = s_d_hrdata_i >> {offset, 3'b000};
        ld_byte  = shifted[7:0];
        ld_half  = offset[1] ? s_d_hrdata_i[31:16] : s_d_hrdata_i[15:0];
        sign_bit = 1'b0;
        aligned  = s_d_hrdata_i;
        if (!s_exma_f_i[1]) begin
            if (s_exma_f_i[0]) begin
                sign_bit = ~s_exma_f_i[2] & ld_half[15];
                aligned  = {{16{sign_bit}}, ld_half};
            end else begin
                sign_bit = ~s_exma_f_i[2] & ld_byte[7];
                aligned  = {{24{sign_bit}}, ld_byte};
            end
        end
    end

    assign we_d = (s_exma_ictrl_i != '0) & (s_exma_imiscon_i == IMISCON_FREE) &
                  (s_exma_rd_i != '0) & ~is_store & ~err_done;

    // MAWB registers: bubble on flush, hold while stalled, otherwise capture MA result
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            s_mawb_ictrl_o   <= '0;
            s_mawb_imiscon_o <= IMISCON_FREE;
            s_mawb_rd_o      <= '0;
            s_mawb_val_o     <= 32'h0;
            s_mawb_we_o      <= 1'b0;
        end else if (s_flush_i || kill_q) begin
            s_mawb_ictrl_o   <= '0;
            s_mawb_imiscon_o <= IMISCON_FREE;
            s_mawb_rd_o      <= '0;
            s_mawb_val_o     <= 32'h0;
            s_mawb_we_o      <= 1'b0;
        end else if (!s_stall_o) begin
            s_mawb_ictrl_o   <= s_exma_ictrl_i;
            s_mawb_imiscon_o <= err_done ? IMISCON_DBER : s_exma_imiscon_i;
            s_mawb_rd_o      <= s_exma_rd_i;
            s_mawb_val_o     <= (is_load && !err_done) ? aligned : s_exma_val_i;
            s_mawb_we_o      <= we_d;
        end
    end
endmodule
